// File: rtl/square_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// square_pattern_gen_if
//   Groups the configuration/start inputs and the sample-stream outputs of
//   square_pattern_gen into one bundle.
//   master : drives start/config and observes the stream (bench or controller)
//   slave  : the pattern generator itself
//   Signals:
//     start       1-cycle pulse, latches config and (re)starts a burst
//     bit_period  clocks per bit
//     num_bits    bits per burst
//     amplitude   unsigned level magnitude
//     seed        PRBS-7 initial state
//     dat         signed sample (+amp / -amp / 0)
//     dat_valid   high on every RUN cycle
//     bit_out     current bit value
//     busy        high in RUN and DONE
//     done        1-cycle end-of-burst pulse
//     edge_cnt    level transitions in current/last burst
// -----------------------------------------------------------------------------
interface square_pattern_gen_if #(
  parameter int DATA_WIDTH = 18,
  parameter int CNT_WIDTH  = 32
);
  logic                         start;
  logic [CNT_WIDTH-1:0]         bit_period;
  logic [CNT_WIDTH-1:0]         num_bits;
  logic [DATA_WIDTH-1:0]        amplitude;
  logic [6:0]                   seed;

  logic signed [DATA_WIDTH-1:0] dat;
  logic                         dat_valid;
  logic                         bit_out;
  logic                         busy;
  logic                         done;
  logic [CNT_WIDTH-1:0]         edge_cnt;

  modport master (
    output start, bit_period, num_bits, amplitude, seed,
    input  dat, dat_valid, bit_out, busy, done, edge_cnt
  );

  modport slave (
    input  start, bit_period, num_bits, amplitude, seed,
    output dat, dat_valid, bit_out, busy, done, edge_cnt
  );
endinterface

// File: rtl/square_pattern_gen.sv
// -----------------------------------------------------------------------------
// square_pattern_gen
//   Transmit-side test source: emits a signed stream of +/-amplitude levels,
//   each bit held bit_period clocks, bits from PRBS-7 (x^7+x^6+1) or 1010...
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    square_pattern_gen_if.slave (config in, sample stream out)
//   Parameters:
//     DATA_WIDTH  sample width (signed)
//     CNT_WIDTH   width of bit_period, num_bits, edge_cnt and counters
//     PATTERN     0 = PRBS-7, 1 = alternating starting with 1
//   All outputs are registered.
// -----------------------------------------------------------------------------
module square_pattern_gen #(
  parameter int DATA_WIDTH = 18,
  parameter int CNT_WIDTH  = 32,
  parameter int PATTERN    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  square_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] AMP_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [6:0]            LFSR_INIT = 7'h7F;
  localparam logic [CNT_WIDTH-1:0]  MIN_PER   = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]  ONE       = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   per_q, per_d;
  logic [CNT_WIDTH-1:0]   nbits_q, nbits_d;
  logic [DATA_WIDTH-1:0]  amp_q, amp_d;
  logic [6:0]             lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0]   smp_q, smp_d;
  logic [CNT_WIDTH-1:0]   bitn_q, bitn_d;
  logic [DATA_WIDTH-1:0]  dat_q, dat_d;
  logic                   valid_q, valid_d;
  logic                   bit_q, bit_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   edge_q, edge_d;

  // Start-time config after sanitising.
  logic [CNT_WIDTH-1:0]   per_start;
  logic [DATA_WIDTH-1:0]  amp_start;
  logic [6:0]             seed_start;
  logic                   first_bit;
  // Bit-advance helpers.
  logic [6:0]             lfsr_step;
  logic [CNT_WIDTH-1:0]   bitn_inc;
  logic                   next_bit;

  function automatic logic [DATA_WIDTH-1:0] level(input logic b,
                                                  input logic [DATA_WIDTH-1:0] amp);
    // Two's complement negate within DATA_WIDTH; amp is already clipped so
    // -amp never overflows.
    return b ? amp : ('0 - amp);
  endfunction

  always_comb begin
    per_start  = (bus.bit_period < MIN_PER) ? MIN_PER : bus.bit_period;
    amp_start  = (bus.amplitude > AMP_MAX) ? AMP_MAX : bus.amplitude;
    seed_start = (bus.seed == 7'h00) ? LFSR_INIT : bus.seed;
    first_bit  = (PATTERN == 1) ? 1'b1 : seed_start[6];
    lfsr_step  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    bitn_inc   = bitn_q + ONE;
    next_bit   = (PATTERN == 1) ? ~bitn_inc[0] : lfsr_step[6];
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    nbits_d = nbits_q;
    amp_d   = amp_q;
    lfsr_d  = lfsr_q;
    smp_d   = smp_q;
    bitn_d  = bitn_q;
    edge_d  = edge_q;
    dat_d   = '0;
    valid_d = 1'b0;
    bit_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    if (bus.start) begin
      // Start has priority in every state: aborts any burst, no done pulse.
      per_d   = per_start;
      nbits_d = bus.num_bits;
      amp_d   = amp_start;
      lfsr_d  = seed_start;
      smp_d   = '0;
      bitn_d  = '0;
      edge_d  = '0;
      busy_d  = 1'b1;
      if (bus.num_bits == '0) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
        valid_d = 1'b1;
        bit_d   = first_bit;
        dat_d   = level(first_bit, amp_start);
      end
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_RUN: begin
          busy_d = 1'b1;
          if (smp_q == per_q - ONE) begin
            if (bitn_inc == nbits_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              // Next bit is loaded on the wrap edge so each bit gets exactly
              // per_q valid cycles.
              smp_d   = '0;
              bitn_d  = bitn_inc;
              lfsr_d  = lfsr_step;
              valid_d = 1'b1;
              bit_d   = next_bit;
              dat_d   = level(next_bit, amp_q);
              if (next_bit != bit_q && edge_q != '1)
                edge_d = edge_q + ONE;
            end
          end else begin
            smp_d   = smp_q + ONE;
            valid_d = 1'b1;
            bit_d   = bit_q;
            dat_d   = dat_q;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      per_q   <= MIN_PER;
      nbits_q <= '0;
      amp_q   <= '0;
      lfsr_q  <= LFSR_INIT;
      smp_q   <= '0;
      bitn_q  <= '0;
      dat_q   <= '0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      nbits_q <= nbits_d;
      amp_q   <= amp_d;
      lfsr_q  <= lfsr_d;
      smp_q   <= smp_d;
      bitn_q  <= bitn_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      edge_q  <= edge_d;
    end
  end

  assign bus.dat       = dat_q;
  assign bus.dat_valid = valid_q;
  assign bus.bit_out   = bit_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.edge_cnt  = edge_q;

endmodule

// File: tb/tb_square_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_square_pattern_gen
//   Drives a PRBS-7 instance and an alternating-pattern instance with the same
//   config and compares every output cycle against a bit-sequence model:
//   PRBS bits follow b[k+7] = b[k] ^ b[k+1] with b[0..6] = seed[6..0].
// -----------------------------------------------------------------------------
module tb_square_pattern_gen;
  localparam int DW = 18;
  localparam int CW = 32;
  localparam int OW = DW + 4 + CW;
  localparam int AMP_LIM = (1 << (DW - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  square_pattern_gen_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus0 ();
  square_pattern_gen_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus1 ();

  square_pattern_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .PATTERN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  square_pattern_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .PATTERN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [6:0] seed;
    int p;
    int n;
    int amp;
    int exp_valid;
    int exp_e0;
    int exp_e1;
    int exp_max1;
    int exp_min1;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Model state for the burst under test.
  int m_p, m_n, m_amp;
  int mb [2][0:599];
  int me [2][0:599];

  // Observations gathered during a burst.
  int seen_valid, max1, min1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] act_out(input int pat);
    if (pat == 0)
      return {bus0.dat, bus0.dat_valid, bus0.bit_out, bus0.busy, bus0.done, bus0.edge_cnt};
    return {bus1.dat, bus1.dat_valid, bus1.bit_out, bus1.busy, bus1.done, bus1.edge_cnt};
  endfunction

  function automatic logic [OW-1:0] exp_out(input int pat, input int i);
    int total, k, e_last;
    logic [DW-1:0] d;
    logic b;
    total  = m_n * m_p;
    e_last = (m_n > 0) ? me[pat][m_n-1] : 0;
    if (i < total) begin
      k = i / m_p;
      b = (mb[pat][k] != 0);
      d = b ? DW'(m_amp) : DW'(-m_amp);
      return {d, 1'b1, b, 1'b1, 1'b0, CW'(me[pat][k])};
    end else if (i == total) begin
      return {DW'(0), 1'b0, 1'b0, 1'b1, 1'b1, CW'(e_last)};
    end
    return {DW'(0), 1'b0, 1'b0, 1'b0, 1'b0, CW'(e_last)};
  endfunction

  task automatic build_model(input vec_t v);
    logic [6:0] s;
    m_p   = (v.p < 2) ? 2 : v.p;
    m_n   = v.n;
    m_amp = (v.amp > AMP_LIM) ? AMP_LIM : v.amp;
    s     = (v.seed == 7'h00) ? 7'h7F : v.seed;
    for (int k = 0; k < m_n; k++) begin
      if (k < 7) mb[0][k] = int'(s[6-k]);
      else       mb[0][k] = mb[0][k-7] ^ mb[0][k-6];
      mb[1][k] = (k % 2 == 0) ? 1 : 0;
      for (int pat = 0; pat < 2; pat++)
        me[pat][k] = (k == 0) ? 0 : me[pat][k-1] + ((mb[pat][k] != mb[pat][k-1]) ? 1 : 0);
    end
  endtask

  task automatic drive_cfg(input vec_t v, input logic st);
    bus0.start = st;           bus1.start = st;
    bus0.bit_period = CW'(v.p); bus1.bit_period = CW'(v.p);
    bus0.num_bits = CW'(v.n);   bus1.num_bits = CW'(v.n);
    bus0.amplitude = DW'(v.amp); bus1.amplitude = DW'(v.amp);
    bus0.seed = v.seed;         bus1.seed = v.seed;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.seed = 7'($urandom);
    v.p    = $urandom_range(0, 6);
    v.n    = $urandom_range(0, 40);
    v.amp  = $urandom_range(0, (1 << DW) - 1);
    v.exp_valid = 0; v.exp_e0 = 0; v.exp_e1 = 0; v.exp_max1 = 0; v.exp_min1 = 0;
    return v;
  endfunction

  // Pulses start with config v at the current negedge, then checks ncyc
  // cycles (ncyc < 0: the full burst, the done cycle and one idle cycle).
  // Returns at the negedge of the last checked cycle, so a following call
  // issues its start during that cycle.
  task automatic do_burst(input vec_t v, input int ncyc);
    int total, d1;
    build_model(v);
    total = m_p * m_n + 2;
    if (ncyc < 0) ncyc = total;
    seen_valid = 0; max1 = 0; min1 = 0;
    drive_cfg(v, 1'b1);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == 0) drive_cfg(rand_vec(), 1'b0);
      check($sformatf("prbs cycle %0d", i), 64'(act_out(0)), 64'(exp_out(0, i)));
      check($sformatf("alt cycle %0d", i),  64'(act_out(1)), 64'(exp_out(1, i)));
      if (bus0.dat_valid) seen_valid++;
      if (bus1.dat_valid) begin
        d1 = int'(bus1.dat);
        if (d1 > max1) max1 = d1;
        if (d1 < min1) min1 = d1;
      end
    end
  endtask

  vec_t tbl [10];
  vec_t v;

  initial begin
    // Expected edge counts below come from the bit sequences directly.
    // Seed 7F gives bits 1111111 000...; two full m-sequence periods have
    // 128 run boundaries cyclically, minus the unseen closing 0->1 wrap = 127.
    tbl[0] = '{7'h7F, 4,   8,   1000,  32,   1,   7,  1000,  -1000};
    tbl[1] = '{7'h7F, 3,  10,    500,  30,   1,   9,   500,   -500};
    tbl[2] = '{7'h7F, 2, 254,    700, 508, 127, 253,   700,   -700};
    tbl[3] = '{7'h7F, 0,   5,     20,  10,   0,   4,    20,    -20};
    tbl[4] = '{7'h7F, 1,   4,     20,   8,   0,   3,    20,    -20};
    tbl[5] = '{7'h7F, 5,   0,     20,   0,   0,   0,     0,      0};
    tbl[6] = '{7'h7F, 2,   3, 131072,   6,   0,   2, 131071, -131071};
    tbl[7] = '{7'h00, 4,   8,   1000,  32,   1,   7,  1000,  -1000};
    tbl[8] = '{7'h7F, 3,   9,      0,  27,   1,   8,     0,      0};
    tbl[9] = '{7'h7F, 2,   3, 262143,   6,   0,   2, 131071, -131071};

    // Reset state.
    rst_n = 1'b0;
    drive_cfg(tbl[0], 1'b0);
    repeat (3) @(negedge clk);
    check("reset prbs", 64'(act_out(0)), 64'(0));
    check("reset alt",  64'(act_out(1)), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", 64'(act_out(0)), 64'(0));

    // Table-driven bursts.
    for (int t = 0; t < 10; t++) begin
      do_burst(tbl[t], -1);
      check($sformatf("vec%0d valid cycles", t), 64'(seen_valid), 64'(tbl[t].exp_valid));
      check($sformatf("vec%0d prbs edge_cnt", t), 64'(bus0.edge_cnt), 64'(tbl[t].exp_e0));
      check($sformatf("vec%0d alt edge_cnt", t), 64'(bus1.edge_cnt), 64'(tbl[t].exp_e1));
      check($sformatf("vec%0d alt max dat", t), 64'(max1), 64'(tbl[t].exp_max1));
      check($sformatf("vec%0d alt min dat", t), 64'(min1), 64'(tbl[t].exp_min1));
    end

    // Restart during cycle 10 of a 40-cycle burst.
    v = '{7'h55, 4, 10, 300, 0, 0, 0, 0, 0};
    do_burst(v, 11);
    v = '{7'h13, 3, 5, 900, 0, 0, 0, 0, 0};
    do_burst(v, -1);

    // Start coincident with the last valid cycle: start wins, no done.
    v = '{7'h2A, 2, 3, 77, 0, 0, 0, 0, 0};
    do_burst(v, 6);
    v = '{7'h01, 3, 4, 55, 0, 0, 0, 0, 0};
    do_burst(v, -1);

    // Start during the DONE cycle.
    v = '{7'h40, 2, 2, 10, 0, 0, 0, 0, 0};
    do_burst(v, 5);
    v = '{7'h7F, 2, 2, 10, 0, 0, 0, 0, 0};
    do_burst(v, -1);

    // Asynchronous reset mid-burst: outputs clear at once, no done follows.
    v = '{7'h7F, 4, 8, 1000, 0, 0, 0, 0, 0};
    do_burst(v, 10);
    rst_n = 1'b0;
    #1;
    check("async reset prbs", 64'(act_out(0)), 64'(0));
    check("async reset alt",  64'(act_out(1)), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post reset idle %0d", i), 64'(act_out(0)), 64'(0));
    end

    // Randomized bursts, some cut short by a restart.
    for (int r = 0; r < 25; r++) begin
      int tot;
      v = rand_vec();
      tot = ((v.p < 2) ? 2 : v.p) * v.n + 2;
      if ($urandom_range(0, 3) == 0) do_burst(v, $urandom_range(1, tot));
      else                           do_burst(v, -1);
    end
    v = '{7'h7F, 2, 2, 5, 0, 0, 0, 0, 0};
    do_burst(v, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
